// File: rtl/galois_scalar_mult_pipe.sv
// Multi-lane pipelined (scalar * elem) mod p: chunked partial products, exact sum, restoring reduction.
// Optional GALOIS_RANGE_CHECK_EN adds out_err, flagging beats with any non-canonical input lane.
module galois_scalar_mult_pipe #(
  parameter int N_BITS = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS =
    N_BITS'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001),
  parameter int SCALAR_BITS = 5,
  parameter int CHUNK_BITS = 27,
  parameter int LANES = 4,
  parameter int TAG_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*SCALAR_BITS-1:0] in_scalar,
  input  logic [LANES*N_BITS-1:0]     in_elem,
  input  logic [TAG_BITS-1:0]         in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*N_BITS-1:0]     out_elem,
`ifdef GALOIS_RANGE_CHECK_EN
  output logic                        out_err,
`endif
  output logic [TAG_BITS-1:0]         out_tag
);

  localparam int LATENCY = 2 + SCALAR_BITS;
  localparam int NCH = (N_BITS + CHUNK_BITS - 1) / CHUNK_BITS;
  localparam int PP_W = SCALAR_BITS + CHUNK_BITS;
  localparam int P_W = N_BITS + SCALAR_BITS;
  localparam int EXT_W = NCH * CHUNK_BITS;
  localparam logic [P_W-1:0] MOD_W = P_W'(PRIME_MODULUS);

  // Handshake: a beat transfers on a rising edge where valid & ready are both high.
  // The whole pipe advances as one (adv) only when the output slot is empty or draining;
  // otherwise every stage holds, so held outputs stay stable and nothing is squeezed.
  logic                adv;
  logic [LATENCY-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [LATENCY];
  logic [EXT_W-1:0]    elem_ext [LANES];
  logic [PP_W-1:0]     pp_d [LANES][NCH];
  logic [PP_W-1:0]     pp_q [LANES][NCH];
  logic [P_W-1:0]      sum_d [LANES];
  logic [P_W-1:0]      red_d [SCALAR_BITS][LANES];
  logic [P_W-1:0]      red_q [SCALAR_BITS+1][LANES];

  assign adv       = out_ready | ~valid_q[LATENCY-1];
  assign in_ready  = adv;
  assign out_valid = valid_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];

  // The element is zero-padded to a whole number of chunks; the top chunk is narrower in effect.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      elem_ext[l] = EXT_W'(in_elem[l*N_BITS +: N_BITS]);
      for (int j = 0; j < NCH; j++) begin
        pp_d[l][j] = PP_W'(in_scalar[l*SCALAR_BITS +: SCALAR_BITS])
                   * PP_W'(elem_ext[l][j*CHUNK_BITS +: CHUNK_BITS]);
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sum_d[l] = '0;
      for (int j = 0; j < NCH; j++) begin
        sum_d[l] = sum_d[l] + (P_W'(pp_q[l][j]) << (j * CHUNK_BITS));
      end
    end
  end

  // Restoring reduction: stage r conditionally removes p << (SCALAR_BITS-1-r).
  always_comb begin
    for (int r = 0; r < SCALAR_BITS; r++) begin
      for (int l = 0; l < LANES; l++) begin
        if (red_q[r][l] >= (MOD_W << (SCALAR_BITS - 1 - r))) begin
          red_d[r][l] = red_q[r][l] - (MOD_W << (SCALAR_BITS - 1 - r));
        end else begin
          red_d[r][l] = red_q[r][l];
        end
      end
    end
  end

  always_comb begin
    out_elem = '0;
    for (int l = 0; l < LANES; l++) begin
      out_elem[l*N_BITS +: N_BITS] = red_q[SCALAR_BITS][l][N_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      tag_q[LATENCY-1] <= '0;
      for (int l = 0; l < LANES; l++) begin
        red_q[SCALAR_BITS][l] <= '0;
      end
    end else if (adv) begin
      valid_q <= {valid_q[LATENCY-2:0], in_valid};
      tag_q[0] <= in_tag;
      for (int s = 1; s < LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
      pp_q <= pp_d;
      for (int l = 0; l < LANES; l++) begin
        red_q[0][l] <= sum_d[l];
        for (int r = 0; r < SCALAR_BITS; r++) begin
          red_q[r+1][l] <= red_d[r][l];
        end
      end
    end
  end

`ifdef GALOIS_RANGE_CHECK_EN
  logic               err_d;
  logic [LATENCY-1:0] err_q;

  always_comb begin
    err_d = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (in_elem[l*N_BITS +: N_BITS] >= PRIME_MODULUS) err_d = 1'b1;
    end
  end

  assign out_err = err_q[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (adv) begin
      err_q <= {err_q[LATENCY-2:0], err_d};
    end
  end
`endif

endmodule

// File: tb/tb_galois_scalar_mult_pipe.sv
// Bench for galois_scalar_mult_pipe: directed boundary beats plus randomized streams vs a mod-arithmetic model.
// Define GALOIS_RANGE_CHECK_EN to also exercise out_err.
module tb_galois_scalar_mult_pipe;
  localparam int NB = 254;
  localparam int SB = 5;
  localparam int LANES = 4;
  localparam int W = 8 + LANES * NB;
  localparam logic [NB-1:0] P =
    NB'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*SB-1:0]   in_scalar;
  logic [LANES*NB-1:0]   in_elem;
  logic [7:0]            in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*NB-1:0]   out_elem;
  logic [7:0]            out_tag;
`ifdef GALOIS_RANGE_CHECK_EN
  logic                  out_err;
`endif

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int gotc_q[$];

  galois_scalar_mult_pipe dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_scalar(in_scalar),
    .in_elem(in_elem),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_elem(out_elem),
`ifdef GALOIS_RANGE_CHECK_EN
    .out_err(out_err),
`endif
    .out_tag(out_tag)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: plain wide multiply then modulo
  function automatic logic [NB-1:0] mulmod(input logic [SB-1:0] s, input logic [NB-1:0] e);
    logic [511:0] x;
    x = 512'(s) * 512'(e);
    x = x % 512'(P);
    return x[NB-1:0];
  endfunction

  function automatic logic [W-1:0] model_beat(input logic [LANES*SB-1:0] s,
                                               input logic [LANES*NB-1:0] e,
                                               input logic [7:0] t);
    logic [LANES*NB-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*NB +: NB] = mulmod(s[l*SB +: SB], e[l*NB +: NB]);
    return {t, r};
  endfunction

  function automatic logic [NB-1:0] rand_elem();
    logic [511:0] x;
    x = '0;
    case ($urandom_range(0, 5))
      0: return '0;
      1: return P - 1'b1;
      default: begin
        for (int i = 0; i < 8; i++) x = {x[479:0], 32'($urandom())};
        x = x % 512'(P);
        return x[NB-1:0];
      end
    endcase
  endfunction

  // driver tasks
  task automatic drive_rand(input logic [7:0] t);
    for (int l = 0; l < LANES; l++) begin
      in_scalar[l*SB +: SB] = SB'($urandom_range(0, 31));
      in_elem[l*NB +: NB] = rand_elem();
    end
    in_tag = t;
  endtask

  // One clock: record accepted beats (as model results) and emitted beats, then move to next negedge.
  task automatic tick(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model_beat(in_scalar, in_elem, in_tag));
    if (out_valid && out_ready) begin
      got_q.push_back({out_tag, out_elem});
      gotc_q.push_back(cycle);
    end
    @(negedge clk);
    cycle++;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    gotc_q.delete();
  endtask

  task automatic test_reset();
    bit acc;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(acc);
    tick(acc);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++;
    if (out_elem !== '0) begin failures++; $display("FAIL reset_out_elem lane0 got=%h want=0", out_elem[NB-1:0]); end
    checks++;
    if (out_tag !== 8'h00) begin failures++; $display("FAIL reset_out_tag got=%h want=00", out_tag); end
    rst = 1'b0;
    clear_queues();
  endtask

  task automatic test_vectors();
    bit acc;
    int lat;
    logic [NB-1:0] want [LANES];
    want[0] = NB'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593effffffc);
    want[1] = NB'(256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593efffffe2);
    want[2] = '0;
    want[3] = NB'(16'h1234);
    clear_queues();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_scalar = {5'd1, 5'd0, 5'd31, 5'd5};
    in_elem = {NB'(16'h1234), P - 1'b1, P - 1'b1, P - 1'b1};
    in_tag = 8'h5A;
    tick(acc);
    in_valid = 1'b0;
    checks++;
    if (!acc) begin failures++; $display("FAIL vec_accept got=%b want=1", acc); end
    lat = 1;
    while (!out_valid && lat < 30) begin
      tick(acc);
      lat++;
    end
    checks++;
    if (lat != 7) begin failures++; $display("FAIL vec_latency got=%0d want=7", lat); end
    tick(acc);
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL vec_count got=%0d want=1", got_q.size());
    end else begin
      for (int l = 0; l < LANES; l++) begin
        checks++;
        if (got_q[0][l*NB +: NB] !== want[l]) begin
          failures++;
          $display("FAIL vec_lane%0d got=%h want=%h", l, got_q[0][l*NB +: NB], want[l]);
        end
      end
      checks++;
      if (got_q[0][W-1 -: 8] !== 8'h5A) begin
        failures++; $display("FAIL vec_tag got=%h want=5a", got_q[0][W-1 -: 8]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int budget = 0;
    int c0;
    clear_queues();
    out_ready = 1'b1;
    c0 = cycle;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      drive_rand(8'(i));
      tick(acc);
      checks++;
      if (!acc) begin failures++; $display("FAIL b2b_accept beat=%0d got=0 want=1", i); end
    end
    in_valid = 1'b0;
    while (got_q.size() < 16 && budget < 40) begin
      tick(acc);
      budget++;
    end
    checks++;
    if (got_q.size() != 16) begin failures++; $display("FAIL b2b_count got=%0d want=16", got_q.size()); end
    if (gotc_q.size() > 0) begin
      checks++;
      if (gotc_q[0] != c0 + 7) begin failures++; $display("FAIL b2b_first_cycle got=%0d want=%0d", gotc_q[0], c0 + 7); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      for (int l = 0; l < LANES; l++) begin
        checks++;
        if (got_q[i][l*NB +: NB] !== exp_q[i][l*NB +: NB]) begin
          failures++;
          $display("FAIL b2b_data beat=%0d lane=%0d got=%h want=%h", i, l, got_q[i][l*NB +: NB], exp_q[i][l*NB +: NB]);
        end
      end
      checks++;
      if (got_q[i][W-1 -: 8] !== 8'(i)) begin
        failures++; $display("FAIL b2b_tag beat=%0d got=%h want=%h", i, got_q[i][W-1 -: 8], 8'(i));
      end
      if (i > 0) begin
        checks++;
        if (gotc_q[i] != gotc_q[i-1] + 1) begin
          failures++; $display("FAIL b2b_gap beat=%0d got_cycle=%0d want_cycle=%0d", i, gotc_q[i], gotc_q[i-1] + 1);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit acc;
    bit stalled = 1'b0;
    int sent = 0;
    int budget = 0;
    logic [W-1:0] snap;
    clear_queues();
    out_ready = 1'b1;
    drive_rand(8'h40);
    while ((sent < 10 || got_q.size() < 10) && budget < 100) begin
      in_valid = (sent < 10);
      if (!stalled && out_valid) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        snap = {out_tag, out_elem};
        for (int k = 0; k < 3; k++) begin
          tick(acc);
          checks++;
          if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b want=1", k, out_valid); end
          checks++;
          if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", k, in_ready); end
          checks++;
          if ({out_tag, out_elem} !== snap) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d tag got=%h want=%h lane0 got=%h want=%h",
                     k, out_tag, snap[W-1 -: 8], out_elem[NB-1:0], snap[NB-1:0]);
          end
        end
        out_ready = 1'b1;
      end
      tick(acc);
      if (acc) begin
        sent++;
        drive_rand(8'(8'h40 + sent));
      end
      budget++;
    end
    in_valid = 1'b0;
    checks++;
    if (!stalled) begin failures++; $display("FAIL stall_seen got=0 want=1"); end
    checks++;
    if (got_q.size() != 10) begin failures++; $display("FAIL stall_count got=%0d want=10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      for (int l = 0; l < LANES; l++) begin
        checks++;
        if (got_q[i][l*NB +: NB] !== exp_q[i][l*NB +: NB]) begin
          failures++;
          $display("FAIL stall_data beat=%0d lane=%0d got=%h want=%h", i, l, got_q[i][l*NB +: NB], exp_q[i][l*NB +: NB]);
        end
      end
      checks++;
      if (got_q[i][W-1 -: 8] !== exp_q[i][W-1 -: 8]) begin
        failures++; $display("FAIL stall_tag beat=%0d got=%h want=%h", i, got_q[i][W-1 -: 8], exp_q[i][W-1 -: 8]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit acc;
    int c0;
    clear_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      drive_rand(8'(8'h60 + i));
      tick(acc);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    clear_queues();
    for (int i = 0; i < 12; i++) tick(acc);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL midrst_stale got=%0d want=0", got_q.size()); end
    in_valid = 1'b1;
    drive_rand(8'hAA);
    c0 = cycle;
    tick(acc);
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick(acc);
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL midrst_count got=%0d want=1", got_q.size());
    end else begin
      checks++;
      if (gotc_q[0] != c0 + 7) begin failures++; $display("FAIL midrst_latency got=%0d want=%0d", gotc_q[0], c0 + 7); end
      checks++;
      if (got_q[0][W-1 -: 8] !== 8'hAA) begin failures++; $display("FAIL midrst_tag got=%h want=aa", got_q[0][W-1 -: 8]); end
      for (int l = 0; l < LANES; l++) begin
        checks++;
        if (got_q[0][l*NB +: NB] !== exp_q[0][l*NB +: NB]) begin
          failures++;
          $display("FAIL midrst_data lane=%0d got=%h want=%h", l, got_q[0][l*NB +: NB], exp_q[0][l*NB +: NB]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit acc = 1'b1;
    int n = 0;
    int budget = 0;
    clear_queues();
    in_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        drive_rand(8'(n));
      end
      tick(acc);
      if (acc) n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (got_q.size() < exp_q.size() && budget < 40) begin
      tick(acc);
      budget++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      for (int l = 0; l < LANES; l++) begin
        checks++;
        if (got_q[i][l*NB +: NB] !== exp_q[i][l*NB +: NB]) begin
          failures++;
          $display("FAIL rand_data beat=%0d lane=%0d got=%h want=%h", i, l, got_q[i][l*NB +: NB], exp_q[i][l*NB +: NB]);
        end
      end
      checks++;
      if (got_q[i][W-1 -: 8] !== exp_q[i][W-1 -: 8]) begin
        failures++; $display("FAIL rand_tag beat=%0d got=%h want=%h", i, got_q[i][W-1 -: 8], exp_q[i][W-1 -: 8]);
      end
    end
  endtask

`ifdef GALOIS_RANGE_CHECK_EN
  task automatic test_range();
    bit acc;
    int budget = 0;
    clear_queues();
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive_rand(8'hE0);
    in_elem = {P - 1'b1, P, P - 1'b1, P - 1'b1};
    tick(acc);
    in_elem = {P - 1'b1, P - 1'b1, P - 1'b1, P - 1'b1};
    in_tag = 8'hE1;
    tick(acc);
    in_valid = 1'b0;
    while (!out_valid && budget < 20) begin
      tick(acc);
      budget++;
    end
    checks++;
    if (out_err !== 1'b1) begin failures++; $display("FAIL range_err_p got=%b want=1", out_err); end
    tick(acc);
    checks++;
    if (out_err !== 1'b0) begin failures++; $display("FAIL range_err_pm1 got=%b want=0", out_err); end
    for (int i = 0; i < 10; i++) tick(acc);
    clear_queues();
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_scalar = '0;
    in_elem = '0;
    in_tag = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_random();
`ifdef GALOIS_RANGE_CHECK_EN
    test_range();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/galois_scalar_mult_pipe.md
Name: galois_scalar_mult_pipe

Overview:
- Multi-lane, fully pipelined modular multiplier: small scalar times field element, mod PRIME_MODULUS.
- Successor to the fixed 5-bit x 254-bit Griffin multiplier.
- Generalised in scalar width, field width, chunking and lane count.
- Adds valid/ready flow control, tag passthrough and reset, and replaces the 22-way comparator chain with a pipelined restoring reduction.
- Sits in the Griffin round datapath wherever a state word is scaled by a small constant.

Parameters:
- N_BITS, 254, field element width.
- PRIME_MODULUS, BN254 scalar prime 0x30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001, modulus p; must satisfy p < 2^N_BITS.
- SCALAR_BITS, 5, scalar width; scalars 0..2^SCALAR_BITS-1 are all legal.
- CHUNK_BITS, 27, num2 slice width per partial product; the final slice is N_BITS mod CHUNK_BITS wide when nonzero.
- LANES, 4, independent parallel lanes sharing one handshake.
- TAG_BITS, 8, sideband tag carried alongside data.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_scalar  in  LANES*SCALAR_BITS  per-lane scalar; lane i at [i*SCALAR_BITS +: SCALAR_BITS]
- in_elem  in  LANES*N_BITS  per-lane field element, canonical (< p)
- in_tag  in  TAG_BITS  beat tag
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_elem  out  LANES*N_BITS  per-lane (scalar*elem) mod p, canonical
- out_tag  out  TAG_BITS  tag of the emitted beat

Behaviour:
- Pipeline depth: LATENCY = 2 + SCALAR_BITS stages (default 7). Each stage holds a valid bit, tag and per-lane data.
- Stage 1: per lane, register scalar * each CHUNK_BITS slice of elem. Each partial product is SCALAR_BITS+CHUNK_BITS wide.
- Stage 2: per lane, sum the shifted partials into a product P of N_BITS+SCALAR_BITS bits. P must be computed exactly; no carry may be dropped.
- Reduction stages r = 0..SCALAR_BITS-1: with k = SCALAR_BITS-1-r, if P >= (p << k) then P <= P - (p << k), else P is unchanged.
- Since P < p<<SCALAR_BITS, the final value is < p. Only the low N_BITS are presented on out_elem.
- Flow control:
  - Global advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv.
  - A beat is accepted iff in_valid & in_ready.
  - When adv=0, every stage register holds its value: no bubbles are squeezed and no data moves.
  - out_valid/out_elem/out_tag stay stable while out_valid & ~out_ready.
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages; data in invalid stages is don't-care.
- Throughput: one beat per cycle while out_ready=1. First output appears LATENCY cycles after acceptance.
- Reset:
  - All stage valid bits clear, so out_valid=0 in the cycle after rst is sampled high.
  - out_elem and out_tag reset to 0.
  - in_ready=1 during and after reset (out_valid=0).
  - A reset asserted mid-stream discards all in-flight beats; no partial beat is emitted afterwards.
- Boundaries:
  - scalar=0 or elem=0 gives 0.
  - scalar=1 gives elem unchanged.
  - elem=p-1 with maximal scalar exercises every reduction stage.
  - Simultaneous accept and emit in the same cycle is legal and loses no beat.
- Lanes are fully independent arithmetically; a single valid/tag covers all lanes.

Optional Feature:
- Macro GALOIS_RANGE_CHECK_EN.
- When defined:
  - Adds output port out_err (1 bit), pipelined alongside the tag, reset 0.
  - out_err is 1 on a beat if any lane's in_elem >= p.
  - Data for such a lane is still computed and is not guaranteed canonical.
- When undefined: no port and no comparator. Inputs are required canonical; non-canonical input gives undefined out_elem.

Test Plan (default parameters, LANES=4):
- Lane0 scalar 5, elem p-1, out_ready=1 -> 7 cycles later out_elem[lane0]=0x30644e72e131a029b85045b68181585d2833e84879b9709143e1f593effffffc (p-5), out_tag matches.
- Scalar 31, elem p-1 -> p-31 = ...43e1f593efffffe2. Scalar 0, elem p-1 -> 0. Scalar 1, elem 0x1234 -> 0x1234. Check all four lanes in one beat.
- Stream 16 back-to-back beats (tags 0..15, random canonical elems), out_ready=1 -> 16 consecutive out_valid cycles, in order, matching a golden mod model.
- Hold out_ready=0 for 3 cycles while out_valid=1 -> outputs stable, in_ready=0, no beat lost or duplicated after release.
- Assert rst for 1 cycle with 5 beats in flight -> out_valid=0 next cycle and no stale beats emerge. Post-reset beat tag 0xAA arrives alone after 7 cycles.
- With GALOIS_RANGE_CHECK_EN, elem=p on lane2 -> out_err=1 for that beat. Elem=p-1 -> out_err=0.
